// File: rtl/gps_fix_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : gps_fix_monitor
// Purpose : Watches the GPS UART byte stream for GGA sentences and derives
//           gps_active / fix / approx status flags.
// Option  : GPS_FIX_CHECKSUM_EN compiles in the NMEA checksum check.
// Revision: 1.0 - initial release
// ============================================================================
module gps_fix_monitor #(
  parameter int unsigned timeout_cycles_p = 12000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       gps_active_o,
  output logic       fix_o,
  output logic       approx_o,
  output logic       sentence_o
);

  localparam int unsigned           c_wd_w      = $clog2(timeout_cycles_p + 1);
  localparam logic [c_wd_w-1:0]     c_wd_max    = c_wd_w'(timeout_cycles_p);
  localparam logic [c_wd_w-1:0]     c_wd_one    = c_wd_w'(1);
  localparam logic [6:0]            c_max_len   = 7'd82;
  localparam logic [7:0]            c_qual_none = 8'h00;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_HDR,
    ST_FIELD
`ifdef GPS_FIX_CHECKSUM_EN
    , ST_CSUM
`endif
  } state_t;

  state_t            r_state, w_state_nx;
  logic [2:0]        r_hdr_cnt, w_hdr_nx;
  logic [2:0]        r_comma_cnt, w_comma_nx;
  logic              r_qual_pend, w_qual_pend_nx;
  logic [7:0]        r_qual, w_qual_nx;
  logic [6:0]        r_len, w_len_nx, w_len_inc;
  logic [c_wd_w-1:0] r_wd;
  logic              r_active, r_fix, r_approx, r_sentence;
  logic              w_commit, w_timeout, w_qual_fix, w_qual_approx;

`ifdef GPS_FIX_CHECKSUM_EN
  logic [7:0]        r_xor, w_xor_nx;
  logic [3:0]        r_csum_hi, w_csum_hi_nx;
  logic              r_csum_idx, w_csum_idx_nx;
  logic [4:0]        w_hex;

  // {valid, nibble} for an ASCII hex digit
  function automatic logic [4:0] hex_val(input logic [7:0] c);
    logic [4:0] v;
    v = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)      v = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) v = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) v = {1'b1, 4'(c - 8'h57)};
    return v;
  endfunction

  assign w_hex = hex_val(data_i);
`endif

  assign w_timeout = (r_wd == c_wd_max) && !valid_i;
  assign w_len_inc = r_len + 7'd1;

  always_comb begin
    w_qual_fix    = 1'b0;
    w_qual_approx = 1'b0;
    case (r_qual)
      "1", "2", "4", "5": w_qual_fix    = 1'b1;
      "6":                w_qual_approx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_HUNT;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx     = r_state;
    w_hdr_nx       = r_hdr_cnt;
    w_comma_nx     = r_comma_cnt;
    w_qual_pend_nx = r_qual_pend;
    w_qual_nx      = r_qual;
    w_len_nx       = r_len;
    w_commit       = 1'b0;
`ifdef GPS_FIX_CHECKSUM_EN
    w_xor_nx       = r_xor;
    w_csum_hi_nx   = r_csum_hi;
    w_csum_idx_nx  = r_csum_idx;
`endif
    if (w_timeout) begin
      w_state_nx = ST_HUNT;
    end else if (valid_i) begin
      if (data_i == "$") begin
        w_state_nx     = ST_HDR;
        w_hdr_nx       = 3'd0;
        w_comma_nx     = 3'd0;
        w_qual_pend_nx = 1'b0;
        w_qual_nx      = c_qual_none;
        w_len_nx       = 7'd0;
`ifdef GPS_FIX_CHECKSUM_EN
        w_xor_nx       = 8'h00;
`endif
      end else begin
        case (r_state)
          ST_HDR: begin
            w_hdr_nx = r_hdr_cnt + 3'd1;
            w_len_nx = w_len_inc;
`ifdef GPS_FIX_CHECKSUM_EN
            w_xor_nx = r_xor ^ data_i;
`endif
            case (r_hdr_cnt)
              3'd2, 3'd3: if (data_i != "G") w_state_nx = ST_HUNT;
              3'd4:       if (data_i != "A") w_state_nx = ST_HUNT;
              3'd5: begin
                if (data_i == ",") begin
                  w_state_nx = ST_FIELD;
                  w_comma_nx = 3'd1;
                end else begin
                  w_state_nx = ST_HUNT;
                end
              end
              default: ;
            endcase
          end
          ST_FIELD: begin
            w_len_nx = w_len_inc;
            if (data_i == "*") begin
`ifdef GPS_FIX_CHECKSUM_EN
              w_state_nx    = ST_CSUM;
              w_csum_idx_nx = 1'b0;
`else
              w_commit      = 1'b1;
              w_state_nx    = ST_HUNT;
`endif
            end else begin
`ifdef GPS_FIX_CHECKSUM_EN
              w_xor_nx = r_xor ^ data_i;
`endif
              // the byte right after comma 6 is the quality byte, even if empty
              if (r_qual_pend) begin
                w_qual_nx      = data_i;
                w_qual_pend_nx = 1'b0;
              end
              if (data_i == ",") begin
                if (r_comma_cnt != 3'd7) w_comma_nx = r_comma_cnt + 3'd1;
                if (r_comma_cnt == 3'd5) w_qual_pend_nx = 1'b1;
              end
              if (w_len_inc > c_max_len) w_state_nx = ST_HUNT;
            end
          end
`ifdef GPS_FIX_CHECKSUM_EN
          ST_CSUM: begin
            if (!w_hex[4]) begin
              w_state_nx = ST_HUNT;
            end else if (!r_csum_idx) begin
              w_csum_hi_nx  = w_hex[3:0];
              w_csum_idx_nx = 1'b1;
            end else begin
              w_commit   = ({r_csum_hi, w_hex[3:0]} == r_xor);
              w_state_nx = ST_HUNT;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hdr_cnt   <= 3'd0;
      r_comma_cnt <= 3'd0;
      r_qual_pend <= 1'b0;
      r_qual      <= c_qual_none;
      r_len       <= 7'd0;
`ifdef GPS_FIX_CHECKSUM_EN
      r_xor       <= 8'h00;
      r_csum_hi   <= 4'd0;
      r_csum_idx  <= 1'b0;
`endif
    end else begin
      r_hdr_cnt   <= w_hdr_nx;
      r_comma_cnt <= w_comma_nx;
      r_qual_pend <= w_qual_pend_nx;
      r_qual      <= w_qual_nx;
      r_len       <= w_len_nx;
`ifdef GPS_FIX_CHECKSUM_EN
      r_xor       <= w_xor_nx;
      r_csum_hi   <= w_csum_hi_nx;
      r_csum_idx  <= w_csum_idx_nx;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wd       <= '0;
      r_active   <= 1'b0;
      r_fix      <= 1'b0;
      r_approx   <= 1'b0;
      r_sentence <= 1'b0;
    end else begin
      r_sentence <= w_commit;
      if (valid_i)               r_wd <= '0;
      else if (r_wd != c_wd_max) r_wd <= r_wd + c_wd_one;
      if (valid_i)        r_active <= 1'b1;
      else if (w_timeout) r_active <= 1'b0;
      if (w_timeout) begin
        r_fix    <= 1'b0;
        r_approx <= 1'b0;
      end else if (w_commit) begin
        r_fix    <= w_qual_fix;
        r_approx <= w_qual_approx;
      end
    end
  end

  assign gps_active_o = r_active;
  assign fix_o        = r_fix;
  assign approx_o     = r_approx;
  assign sentence_o   = r_sentence;

endmodule
`default_nettype wire

// File: tb/tb_gps_fix_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_gps_fix_monitor
// Purpose : Directed GGA sentences with a commit scoreboard for gps_fix_monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gps_fix_monitor;

  localparam int c_timeout = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       gps_active, fix, approx, sentence;

  gps_fix_monitor #(.timeout_cycles_p(c_timeout)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data),
    .valid_i      (valid),
    .gps_active_o (gps_active),
    .fix_o        (fix),
    .approx_o     (approx),
    .sentence_o   (sentence)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int last_valid = 0;

  typedef struct {
    logic fx;
    logic ap;
    int   at;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_flags(input logic fx, input logic ap);
    check("fix_hold", fix, fx);
    check("approx_hold", approx, ap);
  endtask

  // commit monitor: every sentence pulse must match the oldest expected commit
  always @(negedge clk) begin
    exp_t e;
    if (sentence === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_commit: sentence_o=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e = exp_q.pop_front();
        check("commit_fix", fix, e.fx);
        check("commit_approx", approx, e.ap);
        check("commit_cycle", cyc, e.at);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit push, input bit fx, input bit ap);
    exp_t e;
    @(negedge clk);
    data  = b;
    valid = 1'b1;
    last_valid = cyc + 1;
    if (push) begin
      e.fx = fx;
      e.ap = ap;
      e.at = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_sentence(input string s, input bit commit, input bit fx, input bit ap);
    int cidx;
    cidx = -1;
    if (commit) begin
      for (int i = 0; i < s.len(); i++)
        if (s[i] == 8'h2A) cidx = i;
`ifdef GPS_FIX_CHECKSUM_EN
      cidx = cidx + 2;
`endif
    end
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], i == cidx, fx, ap);
      if (i == 0) check("active_after_first_byte", gps_active, 1);
    end
    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    string s1, s6, s0, s_bad, s_inj, s_rmc, s_long;
    int    quiet_bad;

    s1    = "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47\r\n";
    s6    = "$GPGGA,123519,4807.038,N,01131.000,E,6,08,0.9,545.4,M,46.9,M,,*40\r\n";
    s0    = "$GPGGA,123519,4807.038,N,01131.000,E,0,08,0.9,545.4,M,46.9,M,,*46\r\n";
    s_bad = "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*48\r\n";
    s_inj = {"$GPGGA,123519,48", s6};
    s_rmc = "$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A\r\n";
    s_long = "$GPGGA,1,2,3,4,5,1,";
    for (int i = 0; i < 71; i++) s_long = {s_long, "0"};
    s_long = {s_long, "*66\r\n"};

    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_active", gps_active, 0);
    check("reset_fix", fix, 0);
    check("reset_approx", approx, 0);
    check("reset_sentence", sentence, 0);
    rst = 1'b0;

    quiet_bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (gps_active || fix || approx || sentence) quiet_bad++;
    end
    check("idle_outputs_quiet", quiet_bad, 0);

    send_sentence(s1, 1'b1, 1'b1, 1'b0);  check_flags(1'b1, 1'b0);
    send_sentence(s6, 1'b1, 1'b0, 1'b1);  check_flags(1'b0, 1'b1);
    send_sentence(s0, 1'b1, 1'b0, 1'b0);  check_flags(1'b0, 1'b0);
    send_sentence(s1, 1'b1, 1'b1, 1'b0);  check_flags(1'b1, 1'b0);

`ifdef GPS_FIX_CHECKSUM_EN
    send_sentence(s_bad, 1'b0, 1'b0, 1'b0);
`else
    send_sentence(s_bad, 1'b1, 1'b1, 1'b0);
`endif
    check_flags(1'b1, 1'b0);

    send_sentence(s_inj, 1'b1, 1'b0, 1'b1);  check_flags(1'b0, 1'b1);

    // link timeout after a good fix
    send_sentence(s1, 1'b1, 1'b1, 1'b0);
    while (cyc < last_valid + c_timeout) @(negedge clk);
    check("timeout_active_before", gps_active, 1);
    check("timeout_fix_before", fix, 1);
    @(negedge clk);
    check("timeout_active_after", gps_active, 0);
    check("timeout_fix_after", fix, 0);
    check("timeout_approx_after", approx, 0);

    send_sentence(s6, 1'b1, 1'b0, 1'b1);       check_flags(1'b0, 1'b1);
    send_sentence(s_rmc, 1'b0, 1'b0, 1'b0);    check_flags(1'b0, 1'b1);
    send_sentence(s_long, 1'b0, 1'b0, 1'b0);   check_flags(1'b0, 1'b1);

    // reset in the middle of a sentence
    send_sentence(s1, 1'b1, 1'b1, 1'b0);
    send_sentence("$GPGGA,123519,4807.038,N,01131.000,E,1,08", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_active", gps_active, 0);
    check("midreset_fix", fix, 0);
    check("midreset_approx", approx, 0);
    check("midreset_sentence", sentence, 0);
    @(negedge clk);
    rst = 1'b0;
    send_sentence(",0.9,545.4,M,46.9,M,,*47\r\n", 1'b0, 1'b0, 1'b0);
    check_flags(1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
